// File: rtl/cmn_tree_plru_victim.sv
// Tree pseudo-LRU victim selector with a one-entry registered response (valid/ready).
// Define CMN_TREE_PLRU_LOCK_EN to add the lock port and locked-way skipping in the walk.
module cmn_tree_plru_victim #(
  parameter  int WIDTH = 4,
  localparam int DEPTH = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_vld,
  output logic               req_rdy,
  output logic               rsp_vld,
  input  logic               rsp_rdy,
  output logic [WIDTH-1:0]   rsp_way_oh,
  output logic [DEPTH-1:0]   rsp_way_idx,
  output logic               rsp_none,
  input  logic               touch_en,
  input  logic [WIDTH-1:0]   touch_oh,
  input  logic               flush,
`ifdef CMN_TREE_PLRU_LOCK_EN
  input  logic [WIDTH-1:0]   lock,
`endif
  output logic [WIDTH-2:0]   node_q
);

  localparam int NODES = WIDTH - 1;
  localparam int HEAP  = 2 * WIDTH - 1;  // internal nodes followed by one slot per leaf

  // Marks the path of the one-hot way: left-subtree hit sets the node, right-subtree hit clears it.
  function automatic logic [NODES-1:0] tree_update(input logic [NODES-1:0] cur,
                                                   input logic [WIDTH-1:0] oh);
    logic [HEAP-1:0]  hit;
    logic [NODES-1:0] nxt;
    hit = '0;
    nxt = cur;
    for (int w = 0; w < WIDTH; w++) hit[NODES+w] = oh[w];
    for (int i = NODES - 1; i >= 0; i--) hit[i] = hit[2*i+1] | hit[2*i+2];
    for (int i = 0; i < NODES; i++) begin
      if (hit[2*i+1])      nxt[i] = 1'b1;
      else if (hit[2*i+2]) nxt[i] = 1'b0;
    end
    return nxt;
  endfunction

  logic [HEAP-1:0]  sub_locked;
  logic [HEAP-1:0]  on_path;
  logic [NODES-1:0] go_right;
  logic [WIDTH-1:0] vic_oh;
  logic [DEPTH-1:0] vic_idx;
  logic             vic_none;
  logic             req_hs;

  logic [NODES-1:0] node_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic [WIDTH-1:0] rsp_way_oh_q, rsp_way_oh_d;
  logic [DEPTH-1:0] rsp_way_idx_q, rsp_way_idx_d;
  logic             rsp_none_q, rsp_none_d;

  assign req_rdy = ~rsp_vld_q | rsp_rdy;
  assign req_hs  = req_vld & req_rdy;

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sub_locked = '0;
`ifdef CMN_TREE_PLRU_LOCK_EN
    for (int w = 0; w < WIDTH; w++) sub_locked[NODES+w] = lock[w];
    for (int i = NODES - 1; i >= 0; i--) sub_locked[i] = sub_locked[2*i+1] & sub_locked[2*i+2];
`endif
    on_path    = '0;
    on_path[0] = 1'b1;
    go_right   = '0;
    // A fully locked preferred subtree forces the walk to the sibling.
    for (int i = 0; i < NODES; i++) begin
      go_right[i]    = node_q[i] ? ~sub_locked[2*i+2] : sub_locked[2*i+1];
      on_path[2*i+1] = on_path[i] & ~go_right[i];
      on_path[2*i+2] = on_path[i] &  go_right[i];
    end
    vic_none = sub_locked[0];
    vic_oh   = vic_none ? '0 : on_path[HEAP-1:NODES];
    vic_idx  = '0;
    for (int w = 0; w < WIDTH; w++) begin
      if (vic_oh[w]) vic_idx = vic_idx | DEPTH'(w);
    end
  end

  // Touch first, then the victim, so the victim owns any shared path node; flush overrides both.
  always_comb begin
    node_d = node_q;
    if (touch_en) node_d = tree_update(node_d, touch_oh);
    if (req_hs)   node_d = tree_update(node_d, vic_oh);
    if (flush)    node_d = '0;
  end

  always_comb begin
    rsp_vld_d     = rsp_vld_q;
    rsp_way_oh_d  = rsp_way_oh_q;
    rsp_way_idx_d = rsp_way_idx_q;
    rsp_none_d    = rsp_none_q;
    if (req_hs) begin
      rsp_vld_d     = 1'b1;
      rsp_way_oh_d  = vic_oh;
      rsp_way_idx_d = vic_idx;
      rsp_none_d    = vic_none;
    end else if (rsp_rdy) begin
      rsp_vld_d     = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_q        <= '0;
      rsp_vld_q     <= 1'b0;
      rsp_way_oh_q  <= '0;
      rsp_way_idx_q <= '0;
      rsp_none_q    <= 1'b0;
    end else begin
      node_q        <= node_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_way_oh_q  <= rsp_way_oh_d;
      rsp_way_idx_q <= rsp_way_idx_d;
      rsp_none_q    <= rsp_none_d;
    end
  end

  assign rsp_vld     = rsp_vld_q;
  assign rsp_way_oh  = rsp_way_oh_q;
  assign rsp_way_idx = rsp_way_idx_q;
  assign rsp_none    = rsp_none_q;

`ifndef SYNTHESIS
  touch_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
    touch_en |-> $onehot(touch_oh));
`endif

endmodule

// File: tb/tb_cmn_tree_plru_victim.sv
// Self-checking bench for cmn_tree_plru_victim: directed spot checks plus random traffic
// compared every cycle against an index-arithmetic model of the PLRU tree.
module tb_cmn_tree_plru_victim;
  localparam int W = 4;
  localparam int D = $clog2(W);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_vld = 1'b0;
  logic         rsp_rdy = 1'b1;
  logic         touch_en = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] touch_oh = 1;
  logic [W-1:0] lock = '0;
  logic         req_rdy, rsp_vld, rsp_none;
  logic [W-1:0] rsp_way_oh;
  logic [D-1:0] rsp_way_idx;
  logic [W-2:0] node_q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cmn_tree_plru_victim #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_way_oh(rsp_way_oh), .rsp_way_idx(rsp_way_idx), .rsp_none(rsp_none),
    .touch_en(touch_en), .touch_oh(touch_oh), .flush(flush),
`ifdef CMN_TREE_PLRU_LOCK_EN
    .lock(lock),
`endif
    .node_q(node_q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: heap-indexed node array, way bits steer the walk ----
  function automatic logic all_locked(input logic [W-1:0] lk, input int lo, input int span);
    for (int k = lo; k < lo + span; k++) if (!lk[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_walk(input logic [W-2:0] nd, input logic [W-1:0] lk);
    int p, lo, span;
    logic right;
    if (lk == {W{1'b1}}) return -1;
    p = 0; lo = 0; span = W;
    for (int l = 0; l < D; l++) begin
      span = span / 2;
      right = nd[p];
      if (all_locked(lk, right ? lo + span : lo, span)) right = ~right;
      if (right) lo = lo + span;
      p = 2 * p + 1 + int'(right);
    end
    return lo;
  endfunction

  function automatic logic [W-2:0] m_update(input logic [W-2:0] nd, input int w);
    int p, b;
    p = 0;
    for (int l = 0; l < D; l++) begin
      b = (w >> (D - 1 - l)) & 1;
      nd[p] = (b == 0);
      p = 2 * p + 1 + b;
    end
    return nd;
  endfunction

  logic [W-2:0] m_node;
  logic         m_vld, m_none;
  int           m_way;

  always @(posedge clk or negedge rst_n) begin : model
    logic [W-2:0] n;
    int v, tw;
    logic hs;
    if (!rst_n) begin
      m_node <= '0; m_vld <= 1'b0; m_none <= 1'b0; m_way <= 0;
    end else begin
      hs = req_vld && (!m_vld || rsp_rdy);
      v  = m_walk(m_node, lock);
      n  = m_node;
      if (touch_en) begin
        tw = 0;
        for (int k = 0; k < W; k++) if (touch_oh[k]) tw = k;
        n = m_update(n, tw);
      end
      if (hs && v >= 0) n = m_update(n, v);
      if (flush) n = '0;
      m_node <= n;
      if (hs) begin
        m_vld <= 1'b1; m_none <= (v < 0); m_way <= (v < 0) ? 0 : v;
      end else if (rsp_rdy) begin
        m_vld <= 1'b0;
      end
    end
  end

  always begin : compare
    @(posedge clk);
    #1;
    if (rst_n) begin
      check("m_node_q", node_q, m_node);
      check("m_rsp_vld", rsp_vld, m_vld);
      check("m_req_rdy", req_rdy, !m_vld || rsp_rdy);
      if (m_vld) begin
        check("m_rsp_none", rsp_none, m_none);
        check("m_rsp_oh", rsp_way_oh, m_none ? 0 : (1 << m_way));
        check("m_rsp_idx", rsp_way_idx, m_none ? 0 : m_way);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic rv, input logic rr, input logic te, input int tw, input logic fl);
    @(negedge clk);
    req_vld = rv; rsp_rdy = rr; touch_en = te; touch_oh = W'(1) << tw; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_vld = 1'b0; rsp_rdy = 1'b1; touch_en = 1'b0; flush = 1'b0; lock = '0;
    #2;
    check("rst_node", node_q, 0);
    check("rst_vld", rsp_vld, 0);
    check("rst_rdy", req_rdy, 1);
    check("rst_oh", rsp_way_oh, 0);
    check("rst_idx", rsp_way_idx, 0);
    check("rst_none", rsp_none, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_seq [5] = '{0, 2, 1, 3, 0};

    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0, 0);
      check("b2b_vld", rsp_vld, 1);
      check("b2b_idx", rsp_way_idx, exp_seq[i]);
      if (i == 0) check("b2b_node0", node_q, 3'b011);
    end

    do_reset();
    step(0, 1, 1, 2, 0);
    check("touch2_node", node_q, 3'b100);
    step(1, 1, 0, 0, 0);
    check("touch2_victim", rsp_way_idx, 0);

    do_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      check("stall_rdy", req_rdy, 0);
      check("stall_vld", rsp_vld, 1);
      check("stall_oh", rsp_way_oh, 4'b0001);
      check("stall_node", node_q, 3'b011);
    end
    @(negedge clk);
    rsp_rdy = 1'b1;
    #1;
    check("release_rdy", req_rdy, 1);
    @(posedge clk);
    #1;
    check("release_idx", rsp_way_idx, 2);

    do_reset();
    step(1, 1, 1, 0, 0);
    check("same_cyc_idx", rsp_way_idx, 0);
    check("same_cyc_node", node_q, 3'b011);

    do_reset();
    step(0, 1, 1, 2, 0);
    step(0, 1, 1, 0, 0);
    check("pre_flush_node", node_q, 3'b111);
    step(0, 1, 0, 0, 1);
    check("flush_node", node_q, 0);
    step(1, 1, 0, 0, 0);
    check("flush_victim", rsp_way_idx, 0);

`ifdef CMN_TREE_PLRU_LOCK_EN
    do_reset();
    lock = 4'b0011;
    step(1, 1, 0, 0, 0);
    check("lock_idx", rsp_way_idx, 2);
    check("lock_node", node_q, 3'b100);
    lock = 4'b1111;
    step(1, 1, 0, 0, 0);
    check("lockall_none", rsp_none, 1);
    check("lockall_oh", rsp_way_oh, 0);
    check("lockall_node", node_q, 3'b100);
    lock = '0;
`endif

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      @(negedge clk);
      req_vld  = ($urandom_range(0, 3) != 0);
      rsp_rdy  = ($urandom_range(0, 2) != 0);
      touch_en = ($urandom_range(0, 3) == 0);
      touch_oh = W'(1) << $urandom_range(0, W - 1);
      flush    = ($urandom_range(0, 31) == 0);
`ifdef CMN_TREE_PLRU_LOCK_EN
      lock     = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
`endif
    end

    @(negedge clk);
    req_vld = 1'b0; touch_en = 1'b0; flush = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmn_tree_plru_victim.md
# cmn_tree_plru_victim

Stateful tree pseudo-LRU victim selector for a WIDTH-way set. It owns the PLRU node register and walks the tree to pick a replacement victim on request. It returns the victim through a one-entry registered response with a valid/ready handshake, and updates the tree on every victim grant and every hit touch. It is the consumer/decoder counterpart of the combinational PLRU update/age-matrix logic, and sits beside cache and queue allocators in the `cmn` library.

## Interface
Parameters:
- WIDTH, 4, number of ways; power of two, ≥2
- DEPTH, $clog2(WIDTH), tree depth; derived, never overridden

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_vld  input  1  victim request
- req_rdy  output  1  request accepted when req_vld && req_rdy
- rsp_vld  output  1  victim response valid
- rsp_rdy  input  1  response consumed when rsp_vld && rsp_rdy
- rsp_way_oh  output  WIDTH  one-hot victim way
- rsp_way_idx  output  DEPTH  binary victim way
- rsp_none  output  1  no selectable way; tied 0 when lock feature is absent
- touch_en  input  1  hit update strobe
- touch_oh  input  WIDTH  one-hot way being touched
- flush  input  1  synchronous tree clear
- lock  input  WIDTH  ways excluded from selection; present only with CMN_TREE_PLRU_LOCK_EN
- node_q  output  WIDTH-1  current node register, for observation

## Operation
- Node layout: the node at level i, offset j is at index 2^i+j-1. Its left child is index 2p+1 and its right child is index 2p+2.
- Node semantics: node=1 means the left subtree is more recent, so the victim lies right. node=0 means the victim lies left.
- Victim walk: start at the root. At each level, descend right if the node bit is 1, otherwise left. The leaf reached is the victim.
- Tree update for a way w: on each node along w's path, set the bit to 1 if w is in the left subtree and 0 if w is in the right subtree. Off-path nodes are unchanged.
- On request handshake:
  - The victim is computed from the current node_q.
  - The victim is loaded into the response register.
  - The tree is updated with the victim as the most recent way.
- Touch: when touch_en=1, apply the tree update for the way in touch_oh. touch_oh with zero or multiple bits set is illegal; behaviour is undefined, so assert in simulation.
- Same cycle touch and request handshake:
  - The victim uses the pre-update node_q.
  - node_next applies the touch update first, then the victim update; the victim wins on shared path nodes.
- Flush: sets node_q to 0 the next cycle and overrides touch and victim updates. A request accepted in the same cycle still returns the victim computed from the pre-flush node_q.
- Response buffer:
  - req_rdy = ~rsp_vld | rsp_rdy.
  - The response register holds until consumed.
  - Back-to-back requests are supported at full rate.

## Timing
- Reset values:
  - node_q=0, rsp_vld=0, rsp_way_oh=0, rsp_way_idx=0, rsp_none=0.
  - req_rdy=1 after reset, as a combinational result of rsp_vld=0.
- Latency: a request accepted in cycle N produces rsp_vld=1 in cycle N+1. The victim update is visible on node_q in N+1.
- rsp_vld, rsp_way_oh, rsp_way_idx and rsp_none are registered and stable while rsp_vld && ~rsp_rdy.
- Touch and flush affect node_q one cycle after assertion.
- Reset asserted mid-operation: all state clears asynchronously and any pending response is dropped.

## Configuration
- CMN_TREE_PLRU_LOCK_EN defined:
  - The lock port exists.
  - At each walk step, if the preferred child's subtree is entirely locked, the walk takes the other child.
  - If all ways are locked: rsp_vld=1, rsp_none=1, rsp_way_oh=0, rsp_way_idx=0, and node_q is not updated by the request.
  - lock is sampled in the request handshake cycle.
- Not defined:
  - There is no lock port and rsp_none is constant 0.
  - The walk is purely node-driven.

## Test plan
- WIDTH=4, reset, 5 back-to-back requests with rsp_rdy=1 -> victims 0,2,1,3,0; node_q after the first grant is 3'b011.
- After reset, touch way 2, then request -> node_q=3'b100 after the touch; victim is way 0.
- Request accepted, rsp_rdy=0 for 3 cycles -> req_rdy=0 and the response held stable; release -> a new request is accepted in the same cycle.
- Same-cycle touch of way 0 and request from reset -> victim 0, node_q=3'b011.
- Flush asserted with node_q=3'b111 -> node_q=0 next cycle; the next victim is way 0.
- With CMN_TREE_PLRU_LOCK_EN: lock=4'b0011 from reset -> victim 2. lock=4'b1111 -> rsp_none=1, rsp_way_oh=0, node_q unchanged.
